// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle between the sequencer and whoever drives it.
// master = the controlling side, slave = led_seq_ctrl itself.
interface led_seq_ctrl_if;
    logic       en;
    logic       sync_clr;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       step_pulse;

    modport master (
        output en,
        output sync_clr,
        output mode,
        input  sel,
        input  step_pulse
    );

    modport slave (
        input  en,
        input  sync_clr,
        input  mode,
        output sel,
        output step_pulse
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// Timed 3-bit index generator feeding the 3-to-8 one-hot decoder select lines.
// A prescaler produces a tick every CNT_MAX+1 enabled clocks; each tick steps sel by mode.
module led_seq_ctrl #(
    parameter int unsigned CNT_MAX = 24_999_999
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    led_seq_ctrl_if.slave bus
);

    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    dir_e             dir_q, dir_d;
    logic             step_pulse_q, step_pulse_d;
    logic             tick;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q        <= '0;
            sel_q        <= 3'd0;
            dir_q        <= DIR_UP;
            step_pulse_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // sync_clr outranks everything, so a tick landing on a clear is simply lost.
    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        step_pulse_d = 1'b0;
        tick         = bus.en && (cnt_q == CNT_TOP);

        if (bus.sync_clr) begin
            cnt_d = '0;
            sel_d = 3'd0;
            dir_d = DIR_UP;
        end else begin
            if (bus.en) begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            end

            if (tick) begin
                case (bus.mode)
                    MODE_UP: begin
                        sel_d        = sel_q + 3'd1;
                        step_pulse_d = 1'b1;
                    end
                    MODE_DOWN: begin
                        sel_d        = sel_q - 3'd1;
                        step_pulse_d = 1'b1;
                    end
                    MODE_PING: begin
                        step_pulse_d = 1'b1;
                        // Bounce off the ends without dwelling on 7 or 0.
                        if (dir_q == DIR_UP) begin
                            if (sel_q == 3'd7) begin
                                sel_d = 3'd6;
                                dir_d = DIR_DOWN;
                            end else begin
                                sel_d = sel_q + 3'd1;
                            end
                        end else begin
                            if (sel_q == 3'd0) begin
                                sel_d = 3'd1;
                                dir_d = DIR_UP;
                            end else begin
                                sel_d = sel_q - 3'd1;
                            end
                        end
                    end
                    MODE_HOLD: begin
                        sel_d = sel_q;
                    end
                    default: begin
                        sel_d = sel_q;
                    end
                endcase
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with a fast prescaler (CNT_MAX=3).
// A behavioural model tracks the expected index, direction and pulse per clock.
module tb_led_seq_ctrl;

    localparam int CNT_MAX = 3;
    localparam int PERIOD  = CNT_MAX + 1;

    logic sys_clk;
    logic sys_rst_n;

    led_seq_ctrl_if bus ();

    led_seq_ctrl #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: count of enabled cycles within a period, index, bounce direction.
    int m_cnt;
    int m_sel;
    bit m_up;
    bit m_pulse;

    function automatic void model_reset();
        m_cnt   = 0;
        m_sel   = 0;
        m_up    = 1'b1;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_step();
        bit t;
        int nxt;
        if (bus.sync_clr) begin
            model_reset();
            return;
        end
        t       = bus.en && (m_cnt == CNT_MAX);
        m_pulse = t && (bus.mode != 2'b11);
        if (bus.en) m_cnt = (m_cnt + 1) % PERIOD;
        if (t) begin
            case (bus.mode)
                2'b00: m_sel = (m_sel + 1) % 8;
                2'b01: m_sel = (m_sel + 7) % 8;
                2'b10: begin
                    nxt = m_up ? m_sel + 1 : m_sel - 1;
                    if (nxt > 7 || nxt < 0) begin
                        m_up = !m_up;
                        nxt  = m_up ? m_sel + 1 : m_sel - 1;
                    end
                    m_sel = nxt;
                end
                default: ;
            endcase
        end
    endfunction

    task automatic clk_cycle();
        @(posedge sys_clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic do_clear();
        bus.sync_clr = 1'b1;
        clk_cycle();
        bus.sync_clr = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.mode = 2'b00; bus.sync_clr = 1'b0;
        sys_rst_n = 1'b0;
        #3;
        n_checks++;
        if (bus.sel !== 3'd0) begin
            n_fail++; $display("[TB] FAIL reset_sel got=%0d want=0", bus.sel);
        end
        n_checks++;
        if (bus.step_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_pulse got=%b want=0", bus.step_pulse);
        end
        do_reset();
    endtask

    task automatic test_up_wrap();
        int pulses = 0;
        do_reset();
        bus.mode = 2'b00; bus.en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            clk_cycle();
            if (bus.step_pulse === 1'b1) pulses++;
            n_checks++;
            if (bus.sel !== 3'(m_sel) || bus.step_pulse !== m_pulse) begin
                n_fail++;
                $display("[TB] FAIL up_wrap cyc=%0d sel=%0d/%0d pulse=%b/%b", i, bus.sel, m_sel, bus.step_pulse, m_pulse);
            end
        end
        n_checks++;
        if (pulses != 10) begin
            n_fail++; $display("[TB] FAIL up_wrap_pulses got=%0d want=10", pulses);
        end
    endtask

    task automatic test_down_wrap();
        int exp_vals[3] = '{7, 6, 5};
        int k = 0;
        bus.mode = 2'b00;
        do_clear();
        bus.mode = 2'b01;
        for (int i = 0; i < 12; i++) begin
            clk_cycle();
            if (bus.step_pulse === 1'b1 && k < 3) begin
                n_checks++;
                if (bus.sel !== 3'(exp_vals[k])) begin
                    n_fail++; $display("[TB] FAIL down_wrap step=%0d got=%0d want=%0d", k, bus.sel, exp_vals[k]);
                end
                k++;
            end
            n_checks++;
            if (bus.sel !== 3'(m_sel) || bus.step_pulse !== m_pulse) begin
                n_fail++;
                $display("[TB] FAIL down_wrap_model cyc=%0d sel=%0d/%0d pulse=%b/%b", i, bus.sel, m_sel, bus.step_pulse, m_pulse);
            end
        end
        n_checks++;
        if (k != 3) begin
            n_fail++; $display("[TB] FAIL down_wrap_steps got=%0d want=3", k);
        end
    endtask

    task automatic test_ping_pong();
        int exp_vals[16] = '{1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2};
        int k = 0;
        do_reset();
        bus.mode = 2'b10; bus.en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            clk_cycle();
            if (bus.step_pulse === 1'b1) begin
                n_checks++;
                if (k >= 16 || bus.sel !== 3'(exp_vals[k])) begin
                    n_fail++; $display("[TB] FAIL ping_pong step=%0d got=%0d", k, bus.sel);
                end
                k++;
            end
            n_checks++;
            if (bus.sel !== 3'(m_sel) || bus.step_pulse !== m_pulse) begin
                n_fail++;
                $display("[TB] FAIL ping_pong_model cyc=%0d sel=%0d/%0d pulse=%b/%b", i, bus.sel, m_sel, bus.step_pulse, m_pulse);
            end
        end
        n_checks++;
        if (k != 16) begin
            n_fail++; $display("[TB] FAIL ping_pong_steps got=%0d want=16", k);
        end
    endtask

    task automatic test_enable_freeze();
        logic [2:0] held;
        bus.mode = 2'b00; bus.en = 1'b1;
        do_clear();
        clk_cycle();
        clk_cycle();
        held = bus.sel;
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clk_cycle();
            n_checks++;
            if (bus.sel !== held || bus.step_pulse !== 1'b0) begin
                n_fail++; $display("[TB] FAIL en_freeze cyc=%0d sel=%0d/%0d pulse=%b/0", i, bus.sel, held, bus.step_pulse);
            end
        end
        bus.en = 1'b1;
        clk_cycle();
        n_checks++;
        if (bus.step_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL en_resume_early pulse=%b want=0", bus.step_pulse);
        end
        clk_cycle();
        n_checks++;
        if (bus.step_pulse !== 1'b1 || bus.sel !== 3'd1) begin
            n_fail++; $display("[TB] FAIL en_resume_tick pulse=%b/1 sel=%0d/1", bus.step_pulse, bus.sel);
        end
    endtask

    task automatic test_clear_hold();
        logic [2:0] held;
        bus.mode = 2'b00; bus.en = 1'b1;
        do_clear();
        for (int i = 0; i < 23; i++) clk_cycle();
        n_checks++;
        if (bus.sel !== 3'd5 || m_cnt != CNT_MAX) begin
            n_fail++; $display("[TB] FAIL clear_setup sel=%0d want=5", bus.sel);
        end
        do_clear();
        n_checks++;
        if (bus.sel !== 3'd0 || bus.step_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL clear_on_tick sel=%0d/0 pulse=%b/0", bus.sel, bus.step_pulse);
        end
        for (int i = 0; i < 4; i++) clk_cycle();
        n_checks++;
        if (bus.sel !== 3'd1 || bus.step_pulse !== 1'b1) begin
            n_fail++; $display("[TB] FAIL clear_cnt_restart sel=%0d/1 pulse=%b/1", bus.sel, bus.step_pulse);
        end
        held = bus.sel;
        bus.mode = 2'b11;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            clk_cycle();
            n_checks++;
            if (bus.sel !== held || bus.step_pulse !== 1'b0) begin
                n_fail++; $display("[TB] FAIL hold cyc=%0d sel=%0d/%0d pulse=%b/0", i, bus.sel, held, bus.step_pulse);
            end
        end
        bus.mode = 2'b00;
        for (int i = 0; i < PERIOD; i++) begin
            clk_cycle();
            n_checks++;
            if (bus.sel !== 3'(m_sel) || bus.step_pulse !== m_pulse) begin
                n_fail++; $display("[TB] FAIL hold_exit cyc=%0d sel=%0d/%0d pulse=%b/%b", i, bus.sel, m_sel, bus.step_pulse, m_pulse);
            end
        end
    endtask

    task automatic test_async_reset();
        bit saw = 1'b0;
        do_reset();
        bus.mode = 2'b10; bus.en = 1'b1;
        for (int i = 0; i < 10 * PERIOD; i++) clk_cycle();
        n_checks++;
        if (bus.sel !== 3'd4 || m_up) begin
            n_fail++; $display("[TB] FAIL async_setup sel=%0d want=4", bus.sel);
        end
        #2 sys_rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.sel !== 3'd0 || bus.step_pulse !== 1'b0) begin
            n_fail++; $display("[TB] FAIL async_reset sel=%0d/0 pulse=%b/0", bus.sel, bus.step_pulse);
        end
        #2 sys_rst_n = 1'b1;
        for (int i = 0; i < PERIOD; i++) begin
            clk_cycle();
            if (bus.step_pulse === 1'b1) begin
                saw = 1'b1;
                n_checks++;
                if (bus.sel !== 3'd1) begin
                    n_fail++; $display("[TB] FAIL async_first_step got=%0d want=1", bus.sel);
                end
            end
        end
        n_checks++;
        if (!saw) begin
            n_fail++; $display("[TB] FAIL async_no_step got=0 want=1 pulse");
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom_range(0, 3));
            bus.sync_clr = ($urandom_range(0, 59) == 0);
            clk_cycle();
            n_checks++;
            if (bus.sel !== 3'(m_sel) || bus.step_pulse !== m_pulse) begin
                n_fail++;
                $display("[TB] FAIL random cyc=%0d sel=%0d/%0d pulse=%b/%b", i, bus.sel, m_sel, bus.step_pulse, m_pulse);
            end
        end
        bus.sync_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_ping_pong();
        test_enable_freeze();
        test_clear_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Purpose: upstream stage of the 3-to-8 one-hot decoder. It generates the timed 3-bit index that drives the decoder select inputs.

Interface
REQ-001 Parameter CNT_MAX, default 24_999_999: prescaler terminal count, giving one step every CNT_MAX+1 enabled clocks (0.5 s at 50 MHz).
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  1 = prescaler runs; 0 = prescaler and index freeze.
REQ-005 sync_clr  input  1  synchronous clear of prescaler, index and direction.
REQ-006 mode  input  2  step pattern:
- 00 = up-wrap
- 01 = down-wrap
- 10 = ping-pong
- 11 = hold
REQ-007 sel  output  3  registered index; sel[2] drives decoder in1, sel[1] drives in2, sel[0] drives in3.
REQ-008 step_pulse  output  1  registered one-cycle pulse, high in the same cycle a new sel value first appears.

Function
REQ-009 The prescaler cnt SHALL have width ceil(log2(CNT_MAX+1)) bits.
- Increments by 1 each cycle with en=1.
- Returns to 0 after CNT_MAX.
- Holds its value with en=0; it is not cleared.
REQ-010 tick SHALL be true in a cycle where en=1 and cnt==CNT_MAX; it is internal and combinational.
REQ-011 On tick, sel SHALL update at that clock edge according to mode; with no tick, sel SHALL hold.
REQ-012 mode 00: sel <= sel+1 modulo 8, so 7 wraps to 0.
REQ-013 mode 01: sel <= sel-1 modulo 8, so 0 wraps to 7.
REQ-014 mode 10 SHALL use a 2-state direction FSM, UP and DOWN. On each tick:
- UP, sel!=7: sel+1, stay UP.
- UP, sel==7: sel <= 6, go to DOWN.
- DOWN, sel!=0: sel-1, stay DOWN.
- DOWN, sel==0: sel <= 1, go to UP.
- Endpoints are never repeated; the sequence is 0,1,…,7,6,…,1,0,1,…
REQ-015 The direction FSM SHALL change state only on ticks in mode 10; in other modes it retains its state.
REQ-016 mode 11: sel and the FSM SHALL hold, step_pulse SHALL stay 0, and the prescaler keeps counting per REQ-009.
REQ-017 step_pulse SHALL be 1 for exactly one cycle, the cycle following the tick edge, only when the tick occurred in mode 00, 01 or 10; otherwise it is 0.
REQ-018 mode changes SHALL take effect at the next tick; there is no retiming of the prescaler on a mode change.
REQ-019 sync_clr=1 at an edge SHALL force:
- cnt=0, sel=0, FSM=UP, step_pulse=0.
- sync_clr has priority over en and tick; a tick coinciding with sync_clr is discarded.
REQ-020 en dropping mid-count SHALL resume the count from the held cnt value, with no lost or extra tick.
REQ-021 All outputs SHALL come directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-022 sys_rst_n=0 SHALL asynchronously force cnt=0, sel=0, FSM=UP, step_pulse=0, independent of sys_clk.
REQ-023 Reset release SHALL be followed by normal counting from cnt=0 on the first rising edge with sys_rst_n=1.
REQ-024 Reset asserted mid-count or mid-ping-pong SHALL discard all progress; there is no recovery of the prior state.

Verification (CNT_MAX=3, so one tick every 4 enabled cycles)
REQ-025 mode=00, en=1 for 40 cycles after reset:
- sel steps 0,1,…,7,0,1 every 4 cycles.
- step_pulse high 1 cycle per step, 10 pulses total.
REQ-026 mode=01 from sel=0: first step gives sel=7, then 6, 5; step_pulse accompanies each step.
REQ-027 mode=10 for 64 cycles from reset: sel = 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; no value repeats at 7 or 0.
REQ-028 en toggled 0 for 5 cycles while cnt=2:
- cnt and sel frozen during the 5 cycles.
- The next tick arrives 2 enabled cycles after en returns to 1.
REQ-029 Clear and hold behaviour:
- sync_clr=1 in the tick cycle at sel=5 gives sel=0, step_pulse=0, cnt=0.
- mode=11 for 3 tick periods gives sel unchanged and no step_pulse.
REQ-030 sys_rst_n pulsed low asynchronously between edges during ping-pong DOWN at sel=4:
- sel=0 and step_pulse=0 immediately.
- After release, the first step gives sel=1 (FSM is UP).
